line_buffer: RTL and testbench



---
 rtl/line_buffer.sv | 155 +++++++++++++++
 tb/tb_line_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer.sv
// Raster-order line buffer: keeps the previous KERNEL_HEIGHT-1 rows and emits one vertical pixel column per accepted pixel.
// Optional macro LINE_BUFFER_EOL_EN adds registered out_eol/out_eof column markers.
module line_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int KERNEL_HEIGHT = 3,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int OUTPUT_WIDTH  = DATA_WIDTH * KERNEL_HEIGHT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_valid,
`ifdef LINE_BUFFER_EOL_EN
  output logic                    out_eol,
  output logic                    out_eof,
`endif
  input  logic                    out_ready
);

  localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int MEM_ROWS = KERNEL_HEIGHT - 1;

  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;

  // Row memories are never reset; each frame re-primes them before any column is emitted.
  logic [DATA_WIDTH-1:0]   row_mem_q [MEM_ROWS][IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   mem_rd [MEM_ROWS];

  logic in_fire;
  logic out_fire;
  logic streaming;
  logic last_col;
  logic last_row;

  always_comb begin
    streaming = (row_q >= ROW_W'(KERNEL_HEIGHT - 1));
    last_col  = (col_q == COL_W'(IMG_WIDTH - 1));
    last_row  = (row_q == ROW_W'(IMG_HEIGHT - 1));
    // Priming never touches the output register, so it can always accept.
    in_ready  = !streaming || !out_valid_q || out_ready;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid_q && out_ready;
  end

  always_comb begin
    for (int k = 0; k < MEM_ROWS; k++) begin
      mem_rd[k] = row_mem_q[k][col_q];
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_fire) begin
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
        row_d = row_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_fire && streaming) begin
      out_valid_d = 1'b1;
      out_data_d[OUTPUT_WIDTH-1 -: DATA_WIDTH] = in_data;
      for (int k = 0; k < MEM_ROWS; k++) begin
        out_data_d[(MEM_ROWS-1-k)*DATA_WIDTH +: DATA_WIDTH] = mem_rd[k];
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Read-before-write: each deeper row takes the value the shallower row held before this edge.
  always_ff @(posedge clk) begin
    if (!rst && in_fire) begin
      row_mem_q[0][col_q] <= in_data;
      for (int k = 1; k < MEM_ROWS; k++) begin
        row_mem_q[k][col_q] <= mem_rd[k-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef LINE_BUFFER_EOL_EN
  logic eol_q, eol_d;
  logic eof_q, eof_d;

  always_comb begin
    eol_d = eol_q;
    eof_d = eof_q;
    if (in_fire && streaming) begin
      eol_d = last_col;
      eof_d = last_col && last_row;
    end else begin
      eol_d = eol_q;
      eof_d = eof_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eol_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      eol_q <= eol_d;
      eof_q <= eof_d;
    end
  end

  assign out_eol = eol_q;
  assign out_eof = eof_q;
`endif

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer: directed frames plus random valid/ready/data traffic
// checked against a whole-frame image model.
module tb_line_buffer;

  localparam int DW = 8;
  localparam int KH = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int OW = DW * KH;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef LINE_BUFFER_EOL_EN
  logic          out_eol;
  logic          out_eof;
`endif

  always #5 clk = ~clk;

  line_buffer #(
    .DATA_WIDTH(DW), .KERNEL_HEIGHT(KH), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
`ifdef LINE_BUFFER_EOL_EN
    .out_eol(out_eol), .out_eof(out_eof),
`endif
    .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nxt = 0;
  bit pat_mode = 1'b1;
  logic [DW-1:0] rnd_data;

  // Reference: the image as written so far this frame, plus the raster position.
  int mrow = 0;
  int mcol = 0;
  logic [DW-1:0] img [H][W];
  logic [OW+1:0] exp_q[$];

  logic [OW-1:0] out_log[$];
  int            out_cyc[$];
  bit            eol_log[$];
  bit            eof_log[$];
  logic [OW-1:0] golden[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(int n);
    return DW'(((n / W) % H) * 16 + (n % W));
  endfunction

  task automatic model_accept(logic [DW-1:0] d);
    logic [OW+1:0] e;
    img[mrow][mcol] = d;
    if (mrow >= KH - 1) begin
      e = '0;
      for (int j = 0; j < KH; j++) e[(KH-1-j)*DW +: DW] = img[mrow-j][mcol];
      e[OW]   = (mcol == W - 1);
      e[OW+1] = (mcol == W - 1) && (mrow == H - 1);
      exp_q.push_back(e);
    end
    mcol++;
    if (mcol == W) begin
      mcol = 0;
      mrow++;
      if (mrow == H) mrow = 0;
    end
  endtask

  task automatic tick();
    bit fire_in;
    bit fire_out;
    bit exp_rdy;
    logic [OW+1:0] front;
    #1;
    exp_rdy = (mrow < KH - 1) || (exp_q.size() == 0) || out_ready;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      front = exp_q[0];
      check("out_data", out_data, front[OW-1:0]);
`ifdef LINE_BUFFER_EOL_EN
      check("out_eol", out_eol, front[OW]);
      check("out_eof", out_eof, front[OW+1]);
`endif
    end
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    if (fire_out && exp_q.size() != 0) begin
      out_log.push_back(out_data);
      out_cyc.push_back(cyc);
`ifdef LINE_BUFFER_EOL_EN
      eol_log.push_back(out_eol);
      eof_log.push_back(out_eof);
`endif
      void'(exp_q.pop_front());
    end
    if (fire_in) begin
      model_accept(in_data);
      nxt++;
      rnd_data = DW'($urandom);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step(bit v, bit r);
    in_valid  = v;
    out_ready = r;
    in_data   = pat_mode ? pattern(nxt) : rnd_data;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    out_log.delete();
    out_cyc.delete();
    eol_log.delete();
    eof_log.delete();
    mrow = 0;
    mcol = 0;
    nxt = 0;
  endtask

  task automatic compare_golden(string tag, int offset);
    check({tag, "_count"}, out_log.size(), offset + golden.size());
    for (int i = 0; i < golden.size(); i++) begin
      if (offset + i < out_log.size())
        check($sformatf("%s_%0d", tag, i), out_log[offset+i], golden[i]);
    end
  endtask

  initial begin
    logic [DW-1:0] a, b, c;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    rnd_data = DW'($urandom);
    for (int r = KH - 1; r < H; r++) begin
      for (int col = 0; col < W; col++) begin
        a = DW'(r * 16 + col);
        b = DW'((r - 1) * 16 + col);
        c = DW'((r - 2) * 16 + col);
        golden.push_back({a, b, c});
      end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 24'h0);
    check("rst_in_ready", in_ready, 1'b1);

    // Scenarios 1 and 2: full-rate frame
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1);
      if (i < 8) check("prime_no_out", out_valid, 1'b0);
    end
    repeat (2) step(1'b0, 1'b1);
    compare_golden("s1", 0);
    if (out_log.size() == 8) begin
      check("s1_first", out_log[0], 24'h201000);
      check("s1_last", out_log[7], 24'h332313);
      for (int i = 1; i < 8; i++) check("s1_consecutive", out_cyc[i] - out_cyc[i-1], 1);
    end

    // Scenario 3: downstream stall after the first column
    do_reset();
    repeat (9) step(1'b1, 1'b1);
    check("s3_first_valid", out_valid, 1'b1);
    check("s3_first_data", out_data, 24'h201000);
    repeat (5) begin
      step(1'b1, 1'b0);
      check("s3_stall_data", out_data, 24'h201000);
      check("s3_stall_rdy", in_ready, 1'b0);
    end
    repeat (8) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    compare_golden("s3", 0);
    if (out_log.size() >= 3) begin
      check("s3_second", out_log[1], 24'h211101);
      check("s3_third", out_log[2], 24'h221202);
    end

    // Scenario 4: input bubbles every other cycle
    do_reset();
    for (int i = 0; i < 32; i++) step(i % 2 == 0, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    compare_golden("s4", 0);

    // Scenario 5: two frames back to back
    do_reset();
    repeat (32) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    check("s5_count", out_log.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < out_log.size()) check($sformatf("s5_%0d", i), out_log[i], golden[i % 8]);
`ifdef LINE_BUFFER_EOL_EN
      if (i < eol_log.size()) begin
        check("s5_eol", eol_log[i], (i % 4) == 3);
        check("s5_eof", eof_log[i], (i % 8) == 7);
      end
`endif
    end

    // Scenario 6: reset in the middle of a frame
    do_reset();
    repeat (10) step(1'b1, 1'b1);
    check("s6_pending", out_valid, 1'b1);
    do_reset();
    #1;
    check("s6_rst_valid", out_valid, 1'b0);
    repeat (16) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    compare_golden("s6", 0);

    // Random data, valid/ready and occasional resets
    do_reset();
    pat_mode = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    repeat (3) step(1'b0, 1'b1);
    check("rand_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
